// File: rtl/mux2x1.sv
// mux2x1: 2:1 multiplexer that has a combinational output and a registered copy.
// Qualified (in_vld) samples load the registered copy and are also checked for
// select changes, which feed a saturating transition counter.
module mux2x1 #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       x,
   input  logic             s,
   input  logic             in_vld,
   output logic             y,
   output logic             y_q,
   output logic             y_q_vld,
   output logic [CNT_W-1:0] sel_chg_cnt
);

   logic             y_q_q,        y_q_d;
   logic             y_q_vld_q,    y_q_vld_d;
   logic             last_s_q,     last_s_d;
   logic             last_s_vld_q, last_s_vld_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             sel_changed;
   logic             cnt_at_max;

   // Combinational select; indexing by s lets an unknown s propagate X.
   always_comb begin
      y = x[s];
   end

   // Next state for the registered path, select history and transition counter.
   always_comb begin
      y_q_d        = y_q_q;
      y_q_vld_d    = 1'b0;
      last_s_d     = last_s_q;
      last_s_vld_d = last_s_vld_q;
      cnt_d        = cnt_q;
      sel_changed  = last_s_vld_q && (s != last_s_q);
      cnt_at_max   = (cnt_q == '1);
      if (in_vld) begin
         y_q_d        = x[s];
         y_q_vld_d    = 1'b1;
         last_s_d     = s;
         last_s_vld_d = 1'b1;
         if (sel_changed && !cnt_at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers; synchronous active-low reset wins over in_vld.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q_q        <= 1'b0;
         y_q_vld_q    <= 1'b0;
         last_s_q     <= 1'b0;
         last_s_vld_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         y_q_q        <= y_q_d;
         y_q_vld_q    <= y_q_vld_d;
         last_s_q     <= last_s_d;
         last_s_vld_q <= last_s_vld_d;
         cnt_q        <= cnt_d;
      end
   end

   assign y_q         = y_q_q;
   assign y_q_vld     = y_q_vld_q;
   assign sel_chg_cnt = cnt_q;

endmodule

// File: tb/tb_mux2x1.sv
// Directed and randomised checks of mux2x1: truth table without a clock,
// registered path, transition counting, saturation (CNT_W=2) and reset priority.
module tb_mux2x1;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] x = 2'b00;
   logic       s = 1'b0;
   logic       in_vld = 1'b0;

   logic       y, y_q, y_q_vld;
   logic [7:0] cnt;
   logic       y2, y_q2, y_q_vld2;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   // reference model state for the random phase
   logic       m_yq, m_vld, m_ls, m_lsv;
   logic [7:0] m_cnt;
   logic [1:0] m_cnt2;

   mux2x1 #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .s(s), .in_vld(in_vld),
      .y(y), .y_q(y_q), .y_q_vld(y_q_vld), .sel_chg_cnt(cnt)
   );

   mux2x1 #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .x(x), .s(s), .in_vld(in_vld),
      .y(y2), .y_q(y_q2), .y_q_vld(y_q_vld2), .sel_chg_cnt(cnt2)
   );

   always #5 clk = clk_en ? ~clk : clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic qual(input logic [1:0] xv, input logic sv);
      x = xv; s = sv; in_vld = 1'b1;
      tick();
   endtask

   // reference model update for one edge using current inputs
   task automatic model_edge();
      if (!rst_n) begin
         m_yq = 1'b0; m_vld = 1'b0; m_ls = 1'b0; m_lsv = 1'b0;
         m_cnt = 8'd0; m_cnt2 = 2'd0;
      end else if (in_vld) begin
         if (m_lsv && (s != m_ls)) begin
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
         end
         m_yq = s ? x[1] : x[0];
         m_vld = 1'b1; m_ls = s; m_lsv = 1'b1;
      end else begin
         m_vld = 1'b0;
      end
   endtask

   initial begin
      // Combinational truth table with the clock stopped
      x = 2'b10; s = 1'b0; #10; chk("tt_x10_s0", 32'(y), 0);
      x = 2'b10; s = 1'b1; #10; chk("tt_x10_s1", 32'(y), 1);
      x = 2'b01; s = 1'b0; #10; chk("tt_x01_s0", 32'(y), 1);
      x = 2'b01; s = 1'b1; #10; chk("tt_x01_s1", 32'(y), 0);
      x = 2'b00; s = 1'b0; #10; chk("tt_x00_s0", 32'(y), 0);
      x = 2'b00; s = 1'b1; #10; chk("tt_x00_s1", 32'(y), 0);
      x = 2'b11; s = 1'b0; #10; chk("tt_x11_s0", 32'(y), 1);
      x = 2'b11; s = 1'b1; #10; chk("tt_x11_s1", 32'(y), 1);
      rst_n = 1'b0; in_vld = 1'b1; x = 2'b10; s = 1'b1; #10;
      chk("tt_rst_indep", 32'(y), 1);

      // Reset priority with in_vld=1 and x=11
      clk_en = 1'b1;
      rst_n = 1'b0; in_vld = 1'b1; x = 2'b11; s = 1'b0;
      #1; chk("rp_y_before", 32'(y), 1);
      tick();
      chk("rp_y_after", 32'(y), 1);
      chk("rp_yq", 32'(y_q), 0);
      chk("rp_vld", 32'(y_q_vld), 0);
      chk("rp_cnt", 32'(cnt), 0);
      chk("rp_cnt2", 32'(cnt2), 0);

      // Registered path: load then hold with in_vld low
      rst_n = 1'b1;
      qual(2'b10, 1'b1);
      chk("reg_load_yq", 32'(y_q), 1);
      chk("reg_load_vld", 32'(y_q_vld), 1);
      chk("reg_first_cnt", 32'(cnt), 0);
      x = 2'b00; s = 1'b0; in_vld = 1'b0;
      tick();
      chk("reg_hold_yq", 32'(y_q), 1);
      chk("reg_hold_vld", 32'(y_q_vld), 0);
      chk("reg_comb_y", 32'(y), 0);

      // Transition counting 0,1,1,(gap with s toggled),0,1
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      qual(2'b01, 1'b0); chk("tc_0", 32'(cnt), 0);
      chk("tc_0_yq", 32'(y_q), 1);
      qual(2'b01, 1'b1); chk("tc_1", 32'(cnt), 1);
      chk("tc_1_yq", 32'(y_q), 0);
      qual(2'b01, 1'b1); chk("tc_2", 32'(cnt), 1);
      s = 1'b0; in_vld = 1'b0; tick();
      chk("tc_gap", 32'(cnt), 1);
      s = 1'b1; tick();
      chk("tc_gap2", 32'(cnt), 1);
      qual(2'b01, 1'b0); chk("tc_3", 32'(cnt), 2);
      qual(2'b01, 1'b1); chk("tc_4", 32'(cnt), 3);
      chk("tc_cnt2", 32'(cnt2), 3);

      // Saturation with CNT_W=2: six alternating selects, then more
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      qual(2'b10, 1'b0); chk("sat_0", 32'(cnt2), 0);
      qual(2'b10, 1'b1); chk("sat_1", 32'(cnt2), 1);
      qual(2'b10, 1'b0); chk("sat_2", 32'(cnt2), 2);
      qual(2'b10, 1'b1); chk("sat_3", 32'(cnt2), 3);
      qual(2'b10, 1'b0); chk("sat_4", 32'(cnt2), 3);
      qual(2'b10, 1'b1); chk("sat_5", 32'(cnt2), 3);
      chk("sat_wide", 32'(cnt), 5);
      qual(2'b10, 1'b0); chk("sat_6", 32'(cnt2), 3);
      qual(2'b10, 1'b1); chk("sat_7", 32'(cnt2), 3);

      // Mid-stream reset clears everything
      rst_n = 1'b0; in_vld = 1'b1; x = 2'b11; s = 1'b1;
      tick();
      chk("mr_yq", 32'(y_q), 0);
      chk("mr_vld", 32'(y_q_vld), 0);
      chk("mr_cnt", 32'(cnt), 0);
      chk("mr_cnt2", 32'(cnt2), 0);
      rst_n = 1'b1;
      qual(2'b01, 1'b1);
      chk("mr_first_cnt", 32'(cnt), 0);
      chk("mr_first_yq", 32'(y_q), 0);
      chk("mr_first_vld", 32'(y_q_vld), 1);

      // Random stimulus against the reference model
      rst_n = 1'b0; in_vld = 1'b0; model_edge(); tick();
      for (int i = 0; i < 1000; i++) begin
         x      = 2'($urandom_range(0, 3));
         s      = 1'($urandom_range(0, 1));
         in_vld = ($urandom_range(0, 3) != 0);
         rst_n  = ($urandom_range(0, 19) != 0);
         #1;
         chk("rnd_y", 32'(y), 32'(s ? x[1] : x[0]));
         model_edge();
         tick();
         chk("rnd_yq", 32'(y_q), 32'(m_yq));
         chk("rnd_vld", 32'(y_q_vld), 32'(m_vld));
         chk("rnd_cnt", 32'(cnt), 32'(m_cnt));
         chk("rnd_cnt2", 32'(cnt2), 32'(m_cnt2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux2x1.md
MUX2X1 -- requirements
Module: mux2x1

Interface
REQ-001 The block SHALL have the parameter CNT_W, default 8, giving the width of the select-transition counter.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have the port x, input, 2 bits: data legs; x[0] is leg 0, x[1] is leg 1.
REQ-005 The block SHALL have the port s, input, 1 bit: select; 0 picks x[0], 1 picks x[1].
REQ-006 The block SHALL have the port in_vld, input, 1 bit: qualifies x/s for the registered path.
REQ-007 The block SHALL have the port y, output, 1 bit: combinational mux result.
REQ-008 The block SHALL have the port y_q, output, 1 bit: registered mux result.
REQ-009 The block SHALL have the port y_q_vld, output, 1 bit: valid flag for y_q.
REQ-010 The block SHALL have the port sel_chg_cnt, output, CNT_W bits: saturating count of qualified select transitions.

Function
REQ-011 y SHALL equal x[s] at all times, purely combinational, with zero clock latency.
REQ-012 y SHALL be independent of clk, rst_n and in_vld, and valid even with clk not toggling.
REQ-013 On each rising clk edge with rst_n=1 and in_vld=1, y_q SHALL load x[s] and y_q_vld SHALL load 1.
REQ-014 On each rising clk edge with rst_n=1 and in_vld=0, y_q SHALL hold its value and y_q_vld SHALL load 0.
REQ-015 Registered-path latency SHALL be exactly 1 cycle from the sampling edge.
REQ-016 The block SHALL keep an internal last_s register plus last_s_vld flag, updated with s on every qualified edge (rst_n=1, in_vld=1).
REQ-017 On a qualified edge where last_s_vld=1 and s differs from last_s, sel_chg_cnt SHALL increment by 1.
REQ-018 The first qualified edge after reset SHALL NOT count as a transition.
REQ-019 sel_chg_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-020 Edges with in_vld=0 SHALL leave last_s, last_s_vld and sel_chg_cnt unchanged.
REQ-021 When x or s carries X/Z, y SHALL propagate X; there is no masking.

Reset
REQ-022 On a rising clk edge with rst_n=0: y_q=0, y_q_vld=0, sel_chg_cnt=0, last_s=0, last_s_vld=0.
REQ-023 Reset SHALL take priority over in_vld on the same edge.
REQ-024 rst_n SHALL NOT affect y.
REQ-025 Reset asserted mid-stream SHALL clear all state at the next edge.
REQ-026 The first qualified edge after reset release SHALL behave as REQ-013 and REQ-018.

Verification
REQ-027 Combinational truth table, no clock: x=10,s=0 -> y=0; x=10,s=1 -> y=1; x=01,s=0 -> y=1; x=01,s=1 -> y=0; each checked 10 ns after the change; also x=00 -> y=0 and x=11 -> y=1 for both s.
REQ-028 Registered path: reset, then in_vld=1 with x=10,s=1 at edge N -> y_q=1 and y_q_vld=1 after edge N; in_vld=0 at edge N+1 -> y_q=1 held and y_q_vld=0.
REQ-029 Transition count: qualified s sequence 0,1,1,0,1 -> sel_chg_cnt=3; an in_vld=0 cycle with s toggled in between -> no count change.
REQ-030 Saturation: CNT_W=2, 6 qualified alternating s values (5 transitions) -> sel_chg_cnt=3 and it stays at 3.
REQ-031 Reset priority: rst_n=0 with in_vld=1 and x=11 -> after the edge y_q=0, y_q_vld=0, sel_chg_cnt=0, while y=1 throughout.
REQ-032 Random: 1000 cycles of random x, s, in_vld, rst_n compared against a reference model of REQ-011 to REQ-023.
